// File: rtl/simd_compare_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : simd_compare_pipe_if
// Brief    : Beat-level valid/ready bundle for the SIMD compare pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface simd_compare_pipe_if #(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int NUM_LANES     = 4
);
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    logic                           in_valid;
    logic                           in_ready;
    logic [FUNCTION_BITS-1:0]       fn;
    logic                           is_signed;
    logic [NUM_LANES-1:0]           lane_en;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_in0;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_in1;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_LANES*BIT_WIDTH-1:0] data_out;
    logic [NUM_LANES-1:0]           mask_out;
    logic                           any_out;
    logic                           all_out;
    logic [CNT_W-1:0]               pop_out;

    modport master (
        output in_valid, fn, is_signed, lane_en, data_in0, data_in1, out_ready,
        input  in_ready, out_valid, data_out, mask_out, any_out, all_out, pop_out
    );

    modport slave (
        input  in_valid, fn, is_signed, lane_en, data_in0, data_in1, out_ready,
        output in_ready, out_valid, data_out, mask_out, any_out, all_out, pop_out
    );
endinterface
`default_nettype wire

// File: rtl/simd_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module   : simd_compare_pipe
// Brief    : Two-stage multi-lane compare/min/max unit with mask reductions.
// Revision : 1.0 - initial release
// ============================================================================
module simd_compare_pipe #(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int NUM_LANES     = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    simd_compare_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam int DW    = NUM_LANES * BIT_WIDTH;

    localparam logic [FUNCTION_BITS-1:0] FN_EQ  = FUNCTION_BITS'(0);
    localparam logic [FUNCTION_BITS-1:0] FN_NE  = FUNCTION_BITS'(1);
    localparam logic [FUNCTION_BITS-1:0] FN_GT  = FUNCTION_BITS'(2);
    localparam logic [FUNCTION_BITS-1:0] FN_GTE = FUNCTION_BITS'(3);
    localparam logic [FUNCTION_BITS-1:0] FN_LT  = FUNCTION_BITS'(4);
    localparam logic [FUNCTION_BITS-1:0] FN_LTE = FUNCTION_BITS'(5);
    localparam logic [FUNCTION_BITS-1:0] FN_MIN = FUNCTION_BITS'(6);
    localparam logic [FUNCTION_BITS-1:0] FN_MAX = FUNCTION_BITS'(7);

    logic                     s1_valid_q;
    logic [FUNCTION_BITS-1:0] s1_fn_q;
    logic                     s1_signed_q;
    logic [NUM_LANES-1:0]     s1_en_q;
    logic [DW-1:0]            s1_a_q;
    logic [DW-1:0]            s1_b_q;

    logic                     s2_valid_q;
    logic [DW-1:0]            s2_data_q;
    logic [NUM_LANES-1:0]     s2_mask_q;
    logic                     s2_any_q;
    logic                     s2_all_q;
    logic [CNT_W-1:0]         s2_pop_q;

    logic [DW-1:0]            data_d;
    logic [NUM_LANES-1:0]     mask_d;
    logic                     any_d;
    logic                     all_d;
    logic [CNT_W-1:0]         pop_d;

    logic                     s1_adv;
    logic                     s2_adv;

    // Ready ripples combinationally from the consumer back to the producer.
    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_fn_q     <= '0;
            s1_signed_q <= 1'b0;
            s1_en_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_fn_q     <= bus.fn;
                s1_signed_q <= bus.is_signed;
                s1_en_q     <= bus.lane_en;
                s1_a_q      <= bus.data_in0;
                s1_b_q      <= bus.data_in1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [BIT_WIDTH-1:0] a;
        logic [BIT_WIDTH-1:0] b;
        logic [BIT_WIDTH-1:0] r;
        logic                 eq;
        logic                 lt;
        logic                 p;

        assign a  = s1_a_q[i*BIT_WIDTH +: BIT_WIDTH];
        assign b  = s1_b_q[i*BIT_WIDTH +: BIT_WIDTH];
        assign eq = (a == b);
        assign lt = s1_signed_q ? ($signed(a) < $signed(b)) : (a < b);

        always_comb begin
            p = 1'b0;
            r = '0;
            if (s1_en_q[i]) begin
                case (s1_fn_q)
                    FN_EQ:   p = eq;
                    FN_NE:   p = !eq;
                    FN_GT:   p = !lt && !eq;
                    FN_GTE:  p = !lt;
                    FN_LT:   p = lt;
                    FN_LTE:  p = lt || eq;
                    FN_MIN: begin
                        p = lt || eq;
                        r = p ? a : b;
                    end
                    FN_MAX: begin
                        p = !lt;
                        r = p ? a : b;
                    end
                    default: p = 1'b0;
                endcase
                // Predicate ops return the flag in bit 0 of the lane word.
                if (s1_fn_q <= FN_LTE) begin
                    r = {{(BIT_WIDTH-1){1'b0}}, p};
                end
            end
        end

        assign data_d[i*BIT_WIDTH +: BIT_WIDTH] = r;
        assign mask_d[i]                        = p;
    end

    always_comb begin
        any_d = |mask_d;
        all_d = (|s1_en_q) && ((mask_d & s1_en_q) == s1_en_q);
        pop_d = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            pop_d = pop_d + CNT_W'(mask_d[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mask_q  <= '0;
            s2_any_q   <= 1'b0;
            s2_all_q   <= 1'b0;
            s2_pop_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= data_d;
                s2_mask_q <= mask_d;
                s2_any_q  <= any_d;
                s2_all_q  <= all_d;
                s2_pop_q  <= pop_d;
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.data_out  = s2_data_q;
    assign bus.mask_out  = s2_mask_q;
    assign bus.any_out   = s2_any_q;
    assign bus.all_out   = s2_all_q;
    assign bus.pop_out   = s2_pop_q;
endmodule
`default_nettype wire

// File: tb/tb_simd_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_compare_pipe
// Brief    : Randomized and directed bench against a lane-level arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_compare_pipe;
    localparam int L  = 4;
    localparam int W  = 32;
    localparam int DW = L * W;

    typedef struct {
        logic [DW-1:0] data;
        logic [L-1:0]  mask;
        logic          any_v;
        logic          all_v;
        logic [2:0]    pop;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   n_ret;
    exp_t q[$];

    logic          held;
    logic [DW-1:0] h_data;
    logic [L-1:0]  h_mask;
    logic          h_any;
    logic          h_all;
    logic [2:0]    h_pop;

    simd_compare_pipe_if #(.FUNCTION_BITS(4), .BIT_WIDTH(W), .NUM_LANES(L)) bus ();

    simd_compare_pipe #(.FUNCTION_BITS(4), .BIT_WIDTH(W), .NUM_LANES(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                            input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Lane operands are widened to 64-bit integers and compared numerically.
    function automatic exp_t model(input logic [3:0] fn, input logic sgn, input logic [L-1:0] en,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.data = '0;
        e.mask = '0;
        e.pop  = '0;
        for (int i = 0; i < L; i++) begin
            logic [W-1:0] av, bv, r;
            longint       va, vb;
            logic         p;
            av = a[i*W +: W];
            bv = b[i*W +: W];
            va = sgn ? {{32{av[W-1]}}, av} : {32'h0, av};
            vb = sgn ? {{32{bv[W-1]}}, bv} : {32'h0, bv};
            p  = 1'b0;
            r  = '0;
            case (fn)
                4'd0: p = (va == vb);
                4'd1: p = (va != vb);
                4'd2: p = (va >  vb);
                4'd3: p = (va >= vb);
                4'd4: p = (va <  vb);
                4'd5: p = (va <= vb);
                4'd6: p = (va <= vb);
                4'd7: p = (va >= vb);
                default: p = 1'b0;
            endcase
            if (fn == 4'd6 || fn == 4'd7) r = p ? av : bv;
            else if (fn <= 4'd5)          r = {31'h0, p};
            if (!en[i]) begin
                p = 1'b0;
                r = '0;
            end
            e.mask[i]        = p;
            e.data[i*W +: W] = r;
            e.pop            = e.pop + 3'(p);
        end
        e.any_v = (e.mask != 0);
        e.all_v = (en != 0) && ((e.mask & en) == en);
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", DW'(bus.out_valid), DW'(1'b1));
                check("hold_data",  bus.data_out, h_data);
                check("hold_mask",  DW'(bus.mask_out), DW'(h_mask));
                check("hold_red",   DW'({bus.any_out, bus.all_out, bus.pop_out}),
                                    DW'({h_any, h_all, h_pop}));
            end
            check("in_ready", DW'(bus.in_ready), DW'(!(q.size() >= 2 && !bus.out_ready)));
            if (bus.out_valid && q.size() == 0) begin
                check("spurious_out", DW'(bus.out_valid), DW'(1'b0));
            end else if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                e = q.pop_front();
                check("data",  bus.data_out, e.data);
                check("mask",  DW'(bus.mask_out), DW'(e.mask));
                check("any",   DW'(bus.any_out), DW'(e.any_v));
                check("all",   DW'(bus.all_out), DW'(e.all_v));
                check("pop",   DW'(bus.pop_out), DW'(e.pop));
                n_ret++;
            end
            held   = bus.out_valid && !bus.out_ready;
            h_data = bus.data_out;
            h_mask = bus.mask_out;
            h_any  = bus.any_out;
            h_all  = bus.all_out;
            h_pop  = bus.pop_out;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.fn, bus.is_signed, bus.lane_en, bus.data_in0, bus.data_in1));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] rand_op(input logic [W-1:0] other);
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h0;
            3: return 32'hFFFF_FFFF;
            4, 5: return other;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_beat();
        logic [W-1:0] x;
        bus.fn        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        bus.is_signed = 1'($urandom_range(0, 1));
        bus.lane_en   = 4'($urandom_range(0, 15));
        for (int i = 0; i < L; i++) begin
            x = rand_op(32'h5);
            bus.data_in0[i*W +: W] = x;
            bus.data_in1[i*W +: W] = rand_op(x);
        end
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) check({tag, "_accept_timeout"}, DW'(bus.in_ready), DW'(1'b1));
    endtask

    task automatic run_one(input string tag, input logic [3:0] fn, input logic sgn,
                           input logic [L-1:0] en, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] x_data, input logic [L-1:0] x_mask,
                           input logic x_any, input logic x_all, input logic [2:0] x_pop);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.fn        = fn;
        bus.is_signed = sgn;
        bus.lane_en   = en;
        bus.data_in0  = a;
        bus.data_in1  = b;
        wait_accept(tag);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, DW'(bus.out_valid), DW'(1'b0));
        @(negedge clk);
        check({tag, "_lat2"}, DW'(bus.out_valid), DW'(1'b1));
        check({tag, "_data"}, bus.data_out, x_data);
        check({tag, "_mask"}, DW'(bus.mask_out), DW'(x_mask));
        check({tag, "_any"},  DW'(bus.any_out), DW'(x_any));
        check({tag, "_all"},  DW'(bus.all_out), DW'(x_all));
        check({tag, "_pop"},  DW'(bus.pop_out), DW'(x_pop));
    endtask

    initial begin
        logic [DW-1:0] a_min, b_min, ones;
        int r0;
        n_vec = 0; n_err = 0; n_ret = 0; held = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.fn = '0; bus.is_signed = 1'b0;
        bus.lane_en = '0; bus.data_in0 = '0; bus.data_in1 = '0;
        #2;
        check("rst_valid", DW'(bus.out_valid), DW'(1'b0));
        check("rst_data",  bus.data_out, '0);
        check("rst_red",   DW'({bus.mask_out, bus.any_out, bus.all_out, bus.pop_out}), '0);
        #21 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", DW'(bus.in_ready), DW'(1'b1));

        ones = pack4(32'h1, 32'h1, 32'h1, 32'h1);
        run_one("gt_s", 4'd2, 1'b1, 4'hF, {4{32'h8000_0000}}, ones, '0, 4'h0, 1'b0, 1'b0, 3'd0);
        run_one("gt_u", 4'd2, 1'b0, 4'hF, {4{32'h8000_0000}}, ones, ones, 4'hF, 1'b1, 1'b1, 3'd4);
        a_min = pack4(32'd5, -32'sd3, 32'd7, 32'd7);
        b_min = pack4(32'd2, 32'd4, 32'd7, -32'sd8);
        run_one("min", 4'd6, 1'b1, 4'hF, a_min, b_min, pack4(32'd2, -32'sd3, 32'd7, -32'sd8),
                4'b0110, 1'b1, 1'b0, 3'd2);
        run_one("max", 4'd7, 1'b1, 4'hF, a_min, b_min, pack4(32'd5, 32'd4, 32'd7, 32'd7),
                4'b1101, 1'b1, 1'b0, 3'd3);
        run_one("eq_none", 4'd0, 1'b0, 4'h0, a_min, a_min, '0, 4'h0, 1'b0, 1'b0, 3'd0);
        run_one("eq_one", 4'd0, 1'b0, 4'b0010, a_min, a_min, pack4(32'd0, 32'd1, 32'd0, 32'd0),
                4'b0010, 1'b1, 1'b1, 3'd1);
        run_one("bad_fn", 4'hF, 1'b1, 4'hF, a_min, a_min, '0, 4'h0, 1'b0, 1'b0, 3'd0);

        // Back-to-back stream at full rate.
        repeat (3) @(posedge clk);
        r0 = n_ret;
        #1 bus.out_ready = 1'b1; bus.in_valid = 1'b1; rand_beat();
        repeat (5) begin
            @(posedge clk); #1 rand_beat();
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        check("b2b_count", DW'(n_ret - r0), DW'(6));

        // Stall with both stages filling, then release.
        #1 bus.out_ready = 1'b0; bus.in_valid = 1'b1; rand_beat();
        @(negedge clk); check("stall_rdy0", DW'(bus.in_ready), DW'(1'b1));
        @(posedge clk); #1 rand_beat();
        @(negedge clk); check("stall_rdy1", DW'(bus.in_ready), DW'(1'b1));
        @(posedge clk); #1 rand_beat();
        @(negedge clk); check("stall_rdy2", DW'(bus.in_ready), DW'(1'b0));
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_accept("stall");
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        check("stall_drain", DW'(q.size()), DW'(0));

        // Asynchronous reset with both stages occupied.
        #1 bus.out_ready = 1'b0; bus.in_valid = 1'b1; rand_beat();
        @(posedge clk); #1 rand_beat();
        @(posedge clk); #1 bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        q.delete();
        #1;
        check("arst_valid", DW'(bus.out_valid), DW'(1'b0));
        check("arst_data",  bus.data_out, '0);
        check("arst_red",   DW'({bus.mask_out, bus.any_out, bus.all_out, bus.pop_out}), '0);
        @(posedge clk); #3 reset = 1'b0;
        run_one("post_rst", 4'd4, 1'b0, 4'hF, pack4(32'd1, 32'd9, 32'd3, 32'd3),
                pack4(32'd2, 32'd8, 32'd3, 32'd4), pack4(32'd1, 32'd0, 32'd0, 32'd1),
                4'b1001, 1'b1, 1'b0, 3'd2);

        // Randomized traffic with random back-pressure.
        repeat (1500) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rand_beat();
        end
        @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        check("final_drain", DW'(q.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
